// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl
// Multi-digit seven-segment display controller. It latches a packed digit value and the
// per-digit display attributes on a load strobe. It then drives fully registered segment
// outputs with per-digit blanking, leading-zero suppression, timed blinking, optional hex
// glyphs and a live lamp test.
//
// Ports:
//   clk_i          system clock
//   rst_i          synchronous active-high reset (priority over everything)
//   load_i         capture digits_i / blank_i / blink_i / lzs_en_i on this edge
//   digits_i       packed 4-bit codes, digit k at [4k+3:4k], digit 0 rightmost
//   blank_i        per-digit forced blank
//   blink_i        per-digit blink enable
//   lzs_en_i       leading-zero suppression enable
//   lamp_test_i    live lamp test, lights every segment (1-cycle latency)
//   seg_o          registered segments, digit k at [7k+6:7k], bit 0 = a .. bit 6 = g
//   blink_phase_o  blink phase, 1 = blinking digits are dark
module seg_display_ctrl #(
   parameter int unsigned NUM_DIGITS = 6,
   parameter int unsigned BLINK_DIV  = 25000000,
   parameter bit          HEX_EN     = 1'b1,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      load_i,
   input  logic [4*NUM_DIGITS-1:0]   digits_i,
   input  logic [NUM_DIGITS-1:0]     blank_i,
   input  logic [NUM_DIGITS-1:0]     blink_i,
   input  logic                      lzs_en_i,
   input  logic                      lamp_test_i,
   output logic [7*NUM_DIGITS-1:0]   seg_o,
   output logic                      blink_phase_o
);

   localparam int unsigned    DivW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [DivW-1:0] DivLast = DivW'(BLINK_DIV - 1);
   // Segment words in output polarity.
   localparam logic [6:0]     SegDark = ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
   localparam logic [6:0]     SegLit  = ~SegDark;

   logic [4*NUM_DIGITS-1:0] digits_q;
   logic [NUM_DIGITS-1:0]   blank_q;
   logic [NUM_DIGITS-1:0]   blink_q;
   logic                    lzs_q;
   logic [DivW-1:0]         div_q, div_d;
   logic                    phase_q, phase_d;
   logic [7*NUM_DIGITS-1:0] seg_q, seg_d;

   logic [3:0]              code;
   logic                    all_zero;
   logic                    dark;

   // Glyph table in active-low form, gfedcba.
   function automatic logic [6:0] glyph_al(input logic [3:0] c);
      logic [6:0] g;
      case (c)
         4'h0:    g = 7'b1000000;
         4'h1:    g = 7'b1111001;
         4'h2:    g = 7'b0100100;
         4'h3:    g = 7'b0110000;
         4'h4:    g = 7'b0011001;
         4'h5:    g = 7'b0010010;
         4'h6:    g = 7'b0000010;
         4'h7:    g = 7'b1111000;
         4'h8:    g = 7'b0000000;
         4'h9:    g = 7'b0010000;
         4'hA:    g = 7'b0001000;
         4'hB:    g = 7'b0000011;
         4'hC:    g = 7'b1000110;
         4'hD:    g = 7'b0100001;
         4'hE:    g = 7'b0000110;
         default: g = 7'b0001110;
      endcase
      // Without hex support, codes 10..15 fall back to a dash.
      if (!HEX_EN && (c > 4'd9)) begin
         g = 7'b0111111;
      end
      return g;
   endfunction

   // Attribute registers: hold unless loaded.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         digits_q <= '0;
         blank_q  <= '0;
         blink_q  <= '0;
         lzs_q    <= 1'b0;
      end else if (load_i) begin
         digits_q <= digits_i;
         blank_q  <= blank_i;
         blink_q  <= blink_i;
         lzs_q    <= lzs_en_i;
      end
   end

   // Free-running blink divider; the phase flips each time it wraps.
   always_comb begin
      div_d   = div_q + DivW'(1);
      phase_d = phase_q;
      if (div_q == DivLast) begin
         div_d   = '0;
         phase_d = ~phase_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         div_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         div_q   <= div_d;
         phase_q <= phase_d;
      end
   end

   // Segment next-state. Walk from the most significant digit down so all_zero tells whether
   // every digit from the top down to k is a zero code. That is exactly the LZS condition.
   always_comb begin
      seg_d    = '0;
      code     = 4'h0;
      all_zero = 1'b1;
      dark     = 1'b0;
      for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
         code     = digits_q[4*k +: 4];
         all_zero = all_zero & (code == 4'h0);
         dark     = blank_q[k] | (lzs_q & (k != 0) & all_zero) | (blink_q[k] & phase_q);
         if (lamp_test_i) begin
            seg_d[7*k +: 7] = SegLit;
         end else if (dark) begin
            seg_d[7*k +: 7] = SegDark;
         end else begin
            seg_d[7*k +: 7] = glyph_al(code) ^ {7{~ACTIVE_LOW}};
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         seg_q <= {NUM_DIGITS{SegDark}};
      end else begin
         seg_q <= seg_d;
      end
   end

   assign seg_o         = seg_q;
   assign blink_phase_o = phase_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Testbench for seg_display_ctrl. Two instances share one stimulus stream: an active-low
// hex-enabled instance and an active-high, hex-disabled instance. Every cycle both are
// compared against a behavioural model that works from the stored value and cycle counts.
module tb_seg_display_ctrl;

   localparam int ND = 4;
   localparam int BD = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              load = 1'b0;
   logic [4*ND-1:0]   digits = '0;
   logic [ND-1:0]     blank = '0;
   logic [ND-1:0]     blink = '0;
   logic              lzs = 1'b0;
   logic              lamp = 1'b0;
   logic [7*ND-1:0]   seg_a, seg_b;
   logic              phase_a, phase_b;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   seg_display_ctrl #(
      .NUM_DIGITS (ND),
      .BLINK_DIV  (BD),
      .HEX_EN     (1'b1),
      .ACTIVE_LOW (1'b1)
   ) u_dut_a (
      .clk_i         (clk),
      .rst_i         (rst),
      .load_i        (load),
      .digits_i      (digits),
      .blank_i       (blank),
      .blink_i       (blink),
      .lzs_en_i      (lzs),
      .lamp_test_i   (lamp),
      .seg_o         (seg_a),
      .blink_phase_o (phase_a)
   );

   seg_display_ctrl #(
      .NUM_DIGITS (ND),
      .BLINK_DIV  (BD),
      .HEX_EN     (1'b0),
      .ACTIVE_LOW (1'b0)
   ) u_dut_b (
      .clk_i         (clk),
      .rst_i         (rst),
      .load_i        (load),
      .digits_i      (digits),
      .blank_i       (blank),
      .blink_i       (blink),
      .lzs_en_i      (lzs),
      .lamp_test_i   (lamp),
      .seg_o         (seg_b),
      .blink_phase_o (phase_b)
   );

   // Reference model state: the stored value, its attributes and the non-reset edge count.
   logic [4*ND-1:0] m_digits;
   logic [ND-1:0]   m_blank;
   logic [ND-1:0]   m_blink;
   logic            m_lzs;
   int              m_edges;
   logic [7*ND-1:0] exp_a, exp_b;
   logic            exp_phase;
   logic [6:0]      glyph_tbl [16];

   initial begin
      glyph_tbl[0]  = 7'b1000000; glyph_tbl[1]  = 7'b1111001;
      glyph_tbl[2]  = 7'b0100100; glyph_tbl[3]  = 7'b0110000;
      glyph_tbl[4]  = 7'b0011001; glyph_tbl[5]  = 7'b0010010;
      glyph_tbl[6]  = 7'b0000010; glyph_tbl[7]  = 7'b1111000;
      glyph_tbl[8]  = 7'b0000000; glyph_tbl[9]  = 7'b0010000;
      glyph_tbl[10] = 7'b0001000; glyph_tbl[11] = 7'b0000011;
      glyph_tbl[12] = 7'b1000110; glyph_tbl[13] = 7'b0100001;
      glyph_tbl[14] = 7'b0000110; glyph_tbl[15] = 7'b0001110;
   end

   // Phase after n divider edges since reset: it flips once every BD edges.
   function automatic logic phase_of(input int n);
      return ((n / BD) % 2) == 1;
   endfunction

   function automatic logic [7*ND-1:0] model_seg(input bit hex, input bit al, input bit lt);
      logic [7*ND-1:0] w;
      logic [6:0]      d;
      int              code;
      bit              off;
      w = '0;
      for (int k = 0; k < ND; k++) begin
         code = int'(m_digits[4*k +: 4]);
         // Suppressed when the whole value shifted down to digit k is zero.
         off = m_blank[k] || (m_lzs && k != 0 && (m_digits >> (4*k)) == 0)
               || (m_blink[k] && phase_of(m_edges));
         if (lt)                 d = 7'b0000000;
         else if (off)           d = 7'b1111111;
         else if (code < 10)     d = glyph_tbl[code];
         else if (hex)           d = glyph_tbl[code];
         else                    d = 7'b0111111;
         if (!al) d = ~d;
         w[7*k +: 7] = d;
      end
      return w;
   endfunction

   task automatic check_seg(input string tag, input logic [7*ND-1:0] obs,
                            input logic [7*ND-1:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h at %0t", tag, obs, expv, $time);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b at %0t", tag, obs, expv, $time);
      end
   endtask

   // One clock: apply inputs, advance the model across the edge, compare 1 ns later.
   task automatic step(input bit r, input bit ld, input logic [4*ND-1:0] dg,
                       input logic [ND-1:0] bk, input logic [ND-1:0] bl,
                       input bit lz, input bit lt);
      rst = r; load = ld; digits = dg; blank = bk; blink = bl; lzs = lz; lamp = lt;
      @(posedge clk);
      if (r) begin
         exp_a    = {7*ND{1'b1}};
         exp_b    = {7*ND{1'b0}};
         m_digits = '0; m_blank = '0; m_blink = '0; m_lzs = 1'b0;
         m_edges  = 0;
      end else begin
         exp_a = model_seg(1'b1, 1'b1, lt);
         exp_b = model_seg(1'b0, 1'b0, lt);
         if (ld) begin
            m_digits = dg; m_blank = bk; m_blink = bl; m_lzs = lz;
         end
         m_edges++;
      end
      exp_phase = phase_of(m_edges);
      #1;
      check_seg("seg_al_hex", seg_a, exp_a);
      check_seg("seg_ah_nohex", seg_b, exp_b);
      check_bit("phase_a", phase_a, exp_phase);
      check_bit("phase_b", phase_b, exp_phase);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, '0, '0, '0, 0, 0);
   endtask

   logic [4*ND-1:0] rd;
   logic [ND-1:0]   rbk, rbl;

   initial begin
      // Reset, then a plain load; the glyphs appear one edge after the load edge.
      step(1, 0, '0, '0, '0, 0, 0);
      step(1, 1, 16'h9999, '1, '1, 1, 1);
      step(0, 1, 16'h1234, '0, '0, 0, 0);
      idle(2);
      check_seg("load_1234_direct", seg_a, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});

      // Leading-zero suppression.
      step(0, 1, 16'h0050, '0, '0, 1, 0);
      idle(1);
      check_seg("lzs_0050", seg_a, {7'b1111111, 7'b1111111, 7'b0010010, 7'b1000000});
      step(0, 1, 16'h0000, '0, '0, 1, 0);
      idle(1);
      check_seg("lzs_0000", seg_a, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000});
      step(0, 1, 16'h0050, '0, '0, 0, 0);
      idle(1);
      step(0, 1, 16'h00A0, 4'b0010, '0, 1, 0);
      idle(1);

      // Hex glyphs versus dashes.
      step(0, 1, 16'hABEF, '0, '0, 0, 0);
      idle(1);
      check_seg("hex_abef", seg_a, {7'b0001000, 7'b0000011, 7'b0000110, 7'b0001110});
      check_seg("dash_abef", seg_b, {4{7'b1000000}});

      // Blink on digit 0, then a reset partway through a half-period.
      step(0, 1, 16'h1234, '0, 4'b0001, 0, 0);
      idle(13);
      step(1, 0, '0, '0, '0, 0, 0);
      idle(3);

      // Lamp test over fully blanked digits.
      step(0, 1, 16'h5678, 4'b1111, '0, 0, 0);
      idle(1);
      step(0, 0, '0, '0, '0, 0, 1);
      step(0, 0, '0, '0, '0, 0, 1);
      step(0, 0, '0, '0, '0, 0, 1);
      idle(2);

      // Back-to-back loads: last one wins.
      step(0, 1, 16'h1111, '0, '0, 0, 0);
      step(0, 1, 16'h2222, '0, '0, 0, 0);
      idle(2);

      // Randomised traffic with zero-heavy upper nibbles to exercise suppression.
      for (int i = 0; i < 600; i++) begin
         for (int k = 0; k < ND; k++) begin
            rd[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
         end
         rbk = ND'($urandom & $urandom & $urandom);
         rbl = ND'($urandom & $urandom);
         step($urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0, rd, rbk, rbl,
              $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/seg_display_ctrl.md
Name: seg_display_ctrl

Overview:
Parametrised multi-digit seven-segment display controller. It drives NUM_DIGITS directly wired displays from a packed BCD/hex value held in an internal register set. It adds features the single-digit decoder lacks: load strobe, per-digit blanking, leading-zero suppression, timed blinking, hex glyphs and lamp test. It sits between the clock/counter datapath and the board display pins.

Parameters:
NUM_DIGITS, 6, number of digits driven; digit 0 is least significant (rightmost); allowed range 1..8.
BLINK_DIV, 25000000, clk_i cycles per blink half-period; must be >= 1.
HEX_EN, 1, 1: codes 10..15 show A,b,C,d,E,F; 0: codes 10..15 show a dash (segment g only).
ACTIVE_LOW, 1, 1: segment lit = 0; 0: segment lit = 1.

Ports:
clk_i  input  1  system clock; single clock domain.
rst_i  input  1  synchronous active-high reset.
load_i  input  1  when high at a clk_i edge, capture digits_i, blank_i, blink_i and lzs_en_i.
digits_i  input  4*NUM_DIGITS  packed digit codes; bits [4k+3:4k] = digit k.
blank_i  input  NUM_DIGITS  per-digit forced blank.
blink_i  input  NUM_DIGITS  per-digit blink enable.
lzs_en_i  input  1  leading-zero suppression enable.
lamp_test_i  input  1  live, not latched; when high, all segments of all digits are lit.
seg_o  output  7*NUM_DIGITS  registered segments; bits [7k+6:7k] = digit k; bit 0 = a … bit 6 = g.
blink_phase_o  output  1  current blink phase; 1 = blinking digits are dark.

Behaviour:
- Reset (rst_i high at an edge): digit, blank, blink and lzs registers = 0; divider = 0; blink_phase_o = 0; seg_o = all digits dark (all 1s when ACTIVE_LOW=1). rst_i has priority over load_i and lamp_test_i.
- Load: load_i high at edge k updates the internal registers at edge k. seg_o shows the new content after edge k+1 (2-edge latency from the load edge). A new load every cycle is legal; the last load wins. Without a load, the registers hold.
- lamp_test_i: registered into seg_o with 1-cycle latency. It overrides blank, LZS and blink. The registers are unaffected, so the display resumes the stored content the cycle after lamp_test_i drops.
- Blink divider: counts 0..BLINK_DIV-1. On the cycle it equals BLINK_DIV-1 it wraps to 0 and toggles blink_phase_o. Full blink period = 2*BLINK_DIV cycles. The divider free-runs and is unaffected by load_i.
- Per-digit dark condition (evaluated on registered state): blank[k], OR LZS-suppressed(k), OR (blink[k] AND blink_phase_o).
- LZS-suppressed(k): lzs_en = 1, k != 0, and every digit code from NUM_DIGITS-1 down to k equals 0. Only the code value is considered. A forced-blank nonzero digit still stops suppression, and codes 10..15 count as nonzero. Digit 0 is never suppressed, so a value of 0 shows a single "0".
- Glyphs, active-low form with order gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - dash=0111111
- When ACTIVE_LOW=0, every glyph and the dark code are bitwise inverted.
- Output priority per digit: reset > lamp test > dark > glyph.
- Dark means all segments off: 7'b1111111 when ACTIVE_LOW=1, 7'b0000000 when ACTIVE_LOW=0.
- seg_o is fully registered with no combinational path from inputs to outputs.

Test Plan:
1. Reset and load, NUM_DIGITS=4, ACTIVE_LOW=1: assert rst_i 2 cycles -> seg_o=28'hFFFFFFF, blink_phase_o=0. Then load digits_i=16'h1234 at edge k -> after edge k+1, seg_o digit3..0 = 1111001, 0100100, 0110000, 0011001.
2. Leading-zero suppression: load 16'h0050 with lzs_en_i=1 -> digits 3 and 2 dark, digit1=0010010, digit0=1000000. Then load 16'h0000 -> only digit0 lit as "0". With lzs_en_i=0, load 16'h0050 -> digits 3 and 2 show "0".
3. Hex mode: load 16'hABEF with HEX_EN=1 -> glyphs A, b, E, F. Rerun with HEX_EN=0 -> all four digits = 0111111.
4. Blink, BLINK_DIV=4: load blink_i=4'b0001 -> blink_phase_o toggles every 4 cycles. Digit0 is dark exactly while phase=1; digits 1..3 are steady. Reset mid-period -> divider=0 and phase=0 on the next cycle.
5. Lamp test: with digits displayed and blank_i=4'b1111 loaded, pulse lamp_test_i for 3 cycles -> seg_o=28'h0000000 for 3 cycles, offset by 1 cycle. Afterwards all digits return dark.
6. Back-to-back loads: load 16'h1111 then 16'h2222 on consecutive edges -> seg_o shows "1111" for 1 cycle, then "2222". With ACTIVE_LOW=0, every observed segment word equals the bitwise inverse of the ACTIVE_LOW=1 run.
